// File: rtl/wb_stage.sv
// Write-back stage: selects the write-back value, owns the register file, serves two bypassed
// decode read ports and exports a forwarding tap plus retire/halt status. Trace option: WB_TRACE_EN.
module wb_stage #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int FILL_CYCLES = 3
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [104:0]    memwb,
  input  logic            halt_req,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            fwd_we,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic [31:0]     retired,
  output logic            halted
);

  localparam int CW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES + 1) : 1;
  localparam logic [CW-1:0] FILL_LAST = CW'(FILL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  // Bundle field extraction
  logic [4:0]      rd;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] alu_res;
  logic            regwrite;
  logic            memtoreg;
  logic            link;
  logic            bubble;
  logic [XLEN-1:0] pc4;

  assign rd       = memwb[4:0];
  assign ld_data  = memwb[36:5];
  assign alu_res  = memwb[68:37];
  assign regwrite = memwb[69];
  assign memtoreg = memwb[70];
  assign link     = memwb[71];
  assign bubble   = memwb[72];
  assign pc4      = memwb[104:73];

  state_t          state_reg, state_next;
  logic [CW-1:0]   fill_cnt_reg, fill_cnt_next;
  logic            halt_pend_reg, halt_pend_next;
  logic [31:0]     retired_reg, retired_next;
  logic            fwd_we_reg;
  logic [4:0]      fwd_rd_reg;
  logic [XLEN-1:0] fwd_data_reg;
  logic [XLEN-1:0] rf_reg [NREGS];

  logic            run_slot;
  logic            commit_slot;
  logic            commit;
  logic            retire_inc;
  logic [XLEN-1:0] wb_value;
  logic [NREGS-1:0] wr_en;

  always_comb begin
    wb_value = alu_res;
    if (link)
      wb_value = pc4;
    else if (memtoreg)
      wb_value = ld_data;
  end

  // FSM next-state and slot qualification
  always_comb begin
    state_next     = state_reg;
    fill_cnt_next  = fill_cnt_reg;
    halt_pend_next = halt_pend_reg;
    run_slot       = 1'b0;
    commit_slot    = 1'b0;
    case (state_reg)
      S_FILL: begin
        fill_cnt_next = fill_cnt_reg + CW'(1);
        if (halt_req)
          halt_pend_next = 1'b1;
        if (fill_cnt_reg == FILL_LAST)
          state_next = (halt_pend_reg || halt_req) ? S_HALTED : S_RUN;
      end
      S_RUN: begin
        run_slot    = 1'b1;
        commit_slot = 1'b1;
        if (halt_req)
          state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // the one slot still in flight when halt was seen
        commit_slot = 1'b1;
        state_next  = S_HALTED;
      end
      default: begin
        state_next = S_HALTED;
      end
    endcase
  end

  assign commit       = commit_slot && !bubble && regwrite && (rd != 5'd0);
  assign retire_inc   = run_slot && !bubble;
  assign retired_next = retired_reg + (retire_inc ? 32'd1 : 32'd0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= S_FILL;
      fill_cnt_reg  <= '0;
      halt_pend_reg <= 1'b0;
      retired_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      fill_cnt_reg  <= fill_cnt_next;
      halt_pend_reg <= halt_pend_next;
      retired_reg   <= retired_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fwd_we_reg   <= 1'b0;
      fwd_rd_reg   <= '0;
      fwd_data_reg <= '0;
    end else begin
      fwd_we_reg <= commit;
      if (commit) begin
        fwd_rd_reg   <= rd;
        fwd_data_reg <= wb_value;
      end
    end
  end

  // Per-register write enables; x0 never written
  assign wr_en[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_wr_en
      assign wr_en[gi] = commit && (rd == 5'(gi));
    end
  endgenerate

  // Register file is flop-based because reset must clear every entry at once
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NREGS; i++)
        rf_reg[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++)
        if (wr_en[i])
          rf_reg[i] <= wb_value;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0)
      rs1_data = (commit && (rs1_addr == rd)) ? wb_value : rf_reg[rs1_addr];
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0)
      rs2_data = (commit && (rs2_addr == rd)) ? wb_value : rf_reg[rs2_addr];
  end

  assign fwd_we   = fwd_we_reg;
  assign fwd_rd   = fwd_rd_reg;
  assign fwd_data = fwd_data_reg;
  assign retired  = retired_reg;
  assign halted   = (state_reg == S_HALTED);

`ifdef WB_TRACE_EN
  always_ff @(posedge CLK) begin
    if (RESET_N) begin
      if (commit)
        $display("[wb] #%0d pc=%h x%0d=%h", retired_reg, pc4 - 32'd4, rd, wb_value);
      if ((state_next == S_HALTED) && (state_reg != S_HALTED))
        $display("[wb] halted, retired=%0d", retired_next);
    end
  end
`else
  // no trace output in this build
`endif

endmodule
